gnrl_iq_mc_decimator: RTL and testbench

//  Multi-channel I/Q accumulate-and-dump decimator; successor to the single-pair IQ comb decimator.

---
 rtl/gnrl_iq_mc_decimator_pkg.sv | 27 ++
 rtl/gnrl_iq_mc_decimator_round_sat.sv | 48 ++++
 rtl/gnrl_iq_mc_decimator.sv | 192 +++++++++++++++++++
 tb/tb_gnrl_iq_mc_decimator.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnrl_iq_mc_decimator_pkg.sv
// ---------------------------------------------------------------------------
// gnrl_iq_mc_decimator_pkg
//   Shared types and helpers for the multi-channel I/Q decimator.
//   - state_t     : output sequencer states (IDLE / SEND)
//   - clog2_min1  : ceil(log2(n)) clamped to at least 1, for index widths
// ---------------------------------------------------------------------------
package gnrl_iq_mc_decimator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A one-entry selector still needs a 1-bit port, hence the clamp.
    function automatic int clog2_min1(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gnrl_iq_mc_decimator_round_sat.sv
// ---------------------------------------------------------------------------
// gnrl_iq_mc_decimator_round_sat
//   Combinational rounding arithmetic right shift (round half up) followed by
//   saturation from ACC_WIDTH signed down to OUT_WIDTH signed.
//   Ports:
//     sum   in  ACC_WIDTH  signed accumulated sum
//     shift in  SH_WIDTH   right-shift amount (0 = pass through)
//     y     out OUT_WIDTH  rounded, saturated result
// ---------------------------------------------------------------------------
module gnrl_iq_mc_decimator_round_sat #(
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 32,
    parameter int SH_WIDTH  = 6
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    input  logic        [SH_WIDTH-1:0]  shift,
    output logic        [OUT_WIDTH-1:0] y
);

    // One guard bit so that adding the rounding constant cannot wrap.
    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shd;

    always_comb begin
        ext = {sum[ACC_WIDTH-1], sum};
        rnd = '0;
        if (shift != '0) begin
            rnd = {{(EW-1){1'b0}}, 1'b1} << (shift - SH_WIDTH'(1));
        end
        // Both operands are signed, so >>> floors toward -inf: +half then floor = round half up.
        shd = (ext + rnd) >>> shift;

        if (shd > MAX_V) begin
            y = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shd < MIN_V) begin
            y = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            y = shd[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/gnrl_iq_mc_decimator.sv
// ---------------------------------------------------------------------------
// gnrl_iq_mc_decimator
//   Multi-channel I/Q accumulate-and-dump decimator. Sums D accepted samples
//   per channel/phase, rounds/shifts/saturates, and streams the frame as
//   interleaved words I0,Q0,I1,Q1,... on a valid/ready port. A frame that
//   arrives while the previous one is still draining is dropped (sticky
//   overrun flag).
//   Ports:
//     CLK, RESET         clock, synchronous active-high reset
//     dataI, dataQ       NCH packed signed samples, ch k at [k*DATA_WIDTH +: DATA_WIDTH]
//     in_valid           all channels carry a sample this cycle
//     dec_fact           decimation factor (0 and 1 both mean 1)
//     shift              rounding right-shift applied to each sum
//     dataout/out_valid/out_ready   output word stream
//     out_chan/out_isQ/out_last     word tag: channel, I/Q, last of frame
//     overrun/overrun_clr           sticky dropped-frame flag and its clear
// ---------------------------------------------------------------------------
module gnrl_iq_mc_decimator
    import gnrl_iq_mc_decimator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEC_WIDTH  = 16,
    parameter int NCH        = 2,
    parameter int OUT_WIDTH  = 32,
    parameter int SH_WIDTH   = 6
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [NCH*DATA_WIDTH-1:0]       dataI,
    input  logic [NCH*DATA_WIDTH-1:0]       dataQ,
    input  logic                            in_valid,
    input  logic [DEC_WIDTH-1:0]            dec_fact,
    input  logic [SH_WIDTH-1:0]             shift,
    output logic [OUT_WIDTH-1:0]            dataout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [clog2_min1(NCH)-1:0]      out_chan,
    output logic                            out_isQ,
    output logic                            out_last,
    output logic                            overrun,
    input  logic                            overrun_clr
);

    localparam int ACC_WIDTH = DATA_WIDTH + DEC_WIDTH;
    localparam int NW        = 2 * NCH;
    localparam int CH_W      = clog2_min1(NCH);
    localparam int IDX_W     = clog2_min1(NW);

    // Word index w = 2*channel + isQ, matching output order.
    logic signed [ACC_WIDTH-1:0] samp   [NW];
    logic signed [ACC_WIDTH-1:0] acc_q  [NW];
    logic signed [ACC_WIDTH-1:0] acc_d  [NW];
    logic signed [ACC_WIDTH-1:0] s_q    [NW];
    logic signed [ACC_WIDTH-1:0] s_d    [NW];
    logic        [OUT_WIDTH-1:0] scaled [NW];
    logic        [OUT_WIDTH-1:0] hold_q [NW];
    logic        [OUT_WIDTH-1:0] hold_d [NW];

    logic [DEC_WIDTH-1:0] cnt_q, cnt_d;
    logic [DEC_WIDTH-1:0] dlat_q, dlat_d;
    logic [DEC_WIDTH-1:0] d_new, d_cur;
    logic                 dump;
    logic                 s_vld_q, s_vld_d;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 overrun_q, overrun_d;
    logic                 hs, last_word, load;

    for (genvar k = 0; k < NCH; k++) begin : g_samp
        assign samp[2*k]   = {{DEC_WIDTH{dataI[k*DATA_WIDTH+DATA_WIDTH-1]}}, dataI[k*DATA_WIDTH +: DATA_WIDTH]};
        assign samp[2*k+1] = {{DEC_WIDTH{dataQ[k*DATA_WIDTH+DATA_WIDTH-1]}}, dataQ[k*DATA_WIDTH +: DATA_WIDTH]};
    end

    for (genvar w = 0; w < NW; w++) begin : g_rs
        gnrl_iq_mc_decimator_round_sat #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SH_WIDTH  (SH_WIDTH)
        ) u_round_sat (
            .sum   (s_q[w]),
            .shift (shift),
            .y     (scaled[w])
        );
    end

    // Accumulate-and-dump datapath.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q;
        dlat_d  = dlat_q;
        acc_d   = acc_q;
        s_d     = s_q;

        d_new   = (dec_fact == '0) ? DEC_WIDTH'(1) : dec_fact;
        // At the start of a frame the live dec_fact decides; mid-frame the latched D does.
        d_cur   = (cnt_q == '0) ? d_new : dlat_q;
        dump    = in_valid && (cnt_q == d_cur - DEC_WIDTH'(1));
        s_vld_d = dump;

        if (in_valid) begin
            if (cnt_q == '0) begin
                dlat_d = d_new;
            end
            cnt_d = dump ? '0 : cnt_q + DEC_WIDTH'(1);
            for (int w = 0; w < NW; w++) begin
                if (dump) begin
                    s_d[w]   = acc_q[w] + samp[w];
                    acc_d[w] = '0;
                end else begin
                    acc_d[w] = acc_q[w] + samp[w];
                end
            end
        end
    end

    // Output sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        overrun_d = overrun_q & ~overrun_clr;

        load      = s_vld_q;
        hs        = (state_q == ST_SEND) && out_ready;
        last_word = (idx_q == IDX_W'(NW - 1));

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    hold_d  = scaled;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (load && hs && last_word) begin
                    // Back-to-back frame: reload in the same cycle the last word leaves.
                    hold_d = scaled;
                    idx_d  = '0;
                end else begin
                    if (load) begin
                        overrun_d = 1'b1;   // set wins over a coincident clear
                    end
                    if (hs) begin
                        if (last_word) begin
                            idx_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_SEND);
    assign dataout   = out_valid ? hold_q[idx_q] : '0;
    assign out_chan  = CH_W'(idx_q >> 1);
    assign out_isQ   = idx_q[0];
    assign out_last  = out_valid && last_word;
    assign overrun   = overrun_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the sample arrays are reset too, because a reset mid-frame must discard partial sums.
            acc_q     <= '{default: '0};
            s_q       <= '{default: '0};
            hold_q    <= '{default: '0};
            cnt_q     <= '0;
            dlat_q    <= DEC_WIDTH'(1);
            s_vld_q   <= 1'b0;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            acc_q     <= acc_d;
            s_q       <= s_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            dlat_q    <= dlat_d;
            s_vld_q   <= s_vld_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_gnrl_iq_mc_decimator.sv
// ---------------------------------------------------------------------------
// tb_gnrl_iq_mc_decimator
//   Self-checking bench for gnrl_iq_mc_decimator (NCH=2, 32-bit in/out).
//   A frame-level reference model sums samples with plain integer arithmetic,
//   forms each frame as an array of expected words, and tracks which frame is
//   on the output port, which word is due, and whether frames were dropped.
// ---------------------------------------------------------------------------
module tb_gnrl_iq_mc_decimator;

    localparam int NCH = 2;
    localparam int NW  = 2 * NCH;

    logic        CLK;
    logic        RESET;
    logic [63:0] dataI;
    logic [63:0] dataQ;
    logic        in_valid;
    logic [15:0] dec_fact;
    logic [5:0]  shift;
    logic [31:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_chan;
    logic        out_isQ;
    logic        out_last;
    logic        overrun;
    logic        overrun_clr;

    gnrl_iq_mc_decimator #(
        .DATA_WIDTH (32),
        .DEC_WIDTH  (16),
        .NCH        (NCH),
        .OUT_WIDTH  (32),
        .SH_WIDTH   (6)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .dataI       (dataI),
        .dataQ       (dataQ),
        .in_valid    (in_valid),
        .dec_fact    (dec_fact),
        .shift       (shift),
        .dataout     (dataout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .out_isQ     (out_isQ),
        .out_last    (out_last),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_acc [NW] = '{default: 0};
    int          m_cnt      = 0;
    int          m_d        = 1;
    bit          m_pend_v   = 1'b0;
    logic [31:0] m_pend [NW] = '{default: 0};
    bit          m_busy     = 1'b0;
    int          m_idx      = 0;
    logic [31:0] m_cur [NW] = '{default: 0};
    bit          m_ovr      = 1'b0;

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // Round half up, then clamp to the signed 32-bit range.
    function automatic logic [31:0] scale(input longint s, input int sh);
        longint y;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< 31) - 1;
        minv = -(longint'(1) <<< 31);
        if (sh == 0) y = s;
        else         y = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        if (y > maxv)      y = maxv;
        else if (y < minv) y = minv;
        return y[31:0];
    endfunction

    // One clock edge of the model, evaluated on pre-edge input values.
    task automatic model_step();
        bit hs;
        bit last_hs;
        bit set_ovr;
        bit pv_next;
        if (RESET) begin
            m_acc    = '{default: 0};
            m_cnt    = 0;
            m_pend_v = 1'b0;
            m_busy   = 1'b0;
            m_idx    = 0;
            m_ovr    = 1'b0;
        end else begin
            hs      = m_busy && out_ready;
            last_hs = hs && (m_idx == NW - 1);
            set_ovr = 1'b0;
            if (m_pend_v) begin
                if (!m_busy || last_hs) begin
                    m_cur  = m_pend;
                    m_idx  = 0;
                    m_busy = 1'b1;
                end else begin
                    set_ovr = 1'b1;
                    if (hs) m_idx++;
                end
            end else if (hs) begin
                if (last_hs) begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
            if (set_ovr)          m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;

            pv_next = 1'b0;
            if (in_valid) begin
                if (m_cnt == 0) m_d = (dec_fact == 0) ? 1 : int'(dec_fact);
                for (int k = 0; k < NCH; k++) begin
                    m_acc[2*k]   += sx(dataI[k*32 +: 32]);
                    m_acc[2*k+1] += sx(dataQ[k*32 +: 32]);
                end
                m_cnt++;
                if (m_cnt == m_d) begin
                    for (int w = 0; w < NW; w++) begin
                        m_pend[w] = scale(m_acc[w], int'(shift));
                        m_acc[w]  = 0;
                    end
                    m_cnt   = 0;
                    pv_next = 1'b1;
                end
            end
            m_pend_v = pv_next;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", {63'd0, out_valid}, {63'd0, m_busy});
        check("overrun", {63'd0, overrun}, {63'd0, m_ovr});
        if (m_busy) begin
            check("dataout", {32'd0, dataout}, {32'd0, m_cur[m_idx]});
            check("out_chan", {63'd0, out_chan}, 64'(m_idx / 2));
            check("out_isQ", {63'd0, out_isQ}, 64'(m_idx % 2));
            check("out_last", {63'd0, out_last}, {63'd0, (m_idx == NW - 1)});
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        check_outputs();
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge CLK);
        RESET    = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        RESET    = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_cycles(input int n, input int valid_pct, input int ready_pct,
                              input bit rand_data, input int clr_pct);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            in_valid    = ($urandom_range(0, 99) < valid_pct);
            out_ready   = ($urandom_range(0, 99) < ready_pct);
            overrun_clr = ($urandom_range(0, 99) < clr_pct);
            if (rand_data) begin
                dataI = {$urandom, $urandom};
                dataQ = {$urandom, $urandom};
            end
        end
    endtask

    // Returns once out_valid is seen at a negedge, or after a bounded wait.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {63'd0, out_valid}, 64'd1);
    endtask

    int lat;
    bit seen;

    initial begin
        RESET       = 1'b1;
        in_valid    = 1'b0;
        dataI       = '0;
        dataQ       = '0;
        dec_fact    = 16'd1;
        shift       = 6'd0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_dataout", {32'd0, dataout}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_chan", {63'd0, out_chan}, 64'd0);
        check("rst_isQ", {63'd0, out_isQ}, 64'd0);
        check("rst_last", {63'd0, out_last}, 64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        RESET = 1'b0;

        // T1: constant 100, D=4: latency and value
        @(negedge CLK);
        dec_fact = 16'd4;
        dataI    = {32'd100, 32'd100};
        dataQ    = {32'd100, 32'd100};
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        check("t1_latency", 64'(lat), 64'd5);
        check("t1_word0", {32'd0, dataout}, 64'd400);
        run_cycles(40, 100, 100, 1'b0, 0);
        check("t1_no_drop", {63'd0, overrun}, 64'd0);
        run_cycles(20, 0, 100, 1'b0, 0);

        // T2: rounding
        do_reset();
        dec_fact = 16'd16;
        shift    = 6'd4;
        dataI    = {32'hFFFF_FFF9, 32'hFFFF_FFF9};
        dataQ    = {$urandom, $urandom};
        in_valid = 1'b1;
        wait_valid("t2_wait");
        check("t2_minus7", {32'd0, dataout}, {32'd0, 32'hFFFF_FFF9});
        run_cycles(20, 0, 100, 1'b0, 0);
        do_reset();
        dec_fact = 16'd1;
        shift    = 6'd3;
        dataI    = {32'hFFFF_FFF8, 32'hFFFF_FFF8};
        in_valid = 1'b1;
        wait_valid("t2b_wait");
        check("t2_half_up", {32'd0, dataout}, {32'd0, 32'hFFFF_FFFF});
        run_cycles(20, 0, 100, 1'b0, 0);

        // T3: saturation at both rails
        do_reset();
        dec_fact = 16'd2;
        shift    = 6'd0;
        dataI    = {32'd5, 32'h7FFF_FFFF};
        dataQ    = {32'd5, 32'h8000_0000};
        in_valid = 1'b1;
        wait_valid("t3_wait");
        check("t3_sat_hi", {32'd0, dataout}, {32'd0, 32'h7FFF_FFFF});
        @(negedge CLK);
        check("t3_sat_lo", {32'd0, dataout}, {32'd0, 32'h8000_0000});
        check("t3_isQ", {63'd0, out_isQ}, 64'd1);
        run_cycles(20, 0, 100, 1'b0, 0);

        // T4: backpressure, drops, overrun clear
        do_reset();
        dec_fact = 16'd2;
        run_cycles(20, 100, 0, 1'b1, 0);
        check("t4_overrun_set", {63'd0, overrun}, 64'd1);
        run_cycles(12, 0, 100, 1'b0, 0);
        overrun_clr = 1'b1;
        @(negedge CLK);
        overrun_clr = 1'b0;
        check("t4_overrun_clr", {63'd0, overrun}, 64'd0);

        // T5: dec_fact changes mid-frame, and dec_fact=0
        do_reset();
        shift    = 6'd1;
        dec_fact = 16'd4;
        run_cycles(2, 100, 100, 1'b1, 0);
        dec_fact = 16'd8;
        run_cycles(30, 100, 100, 1'b1, 0);
        dec_fact = 16'd0;
        run_cycles(20, 100, 100, 1'b1, 0);
        run_cycles(20, 0, 100, 1'b0, 0);

        // T6: reset mid-accumulation and mid-SEND, then gapped input
        do_reset();
        shift    = 6'd0;
        dec_fact = 16'd4;
        run_cycles(2, 100, 100, 1'b1, 0);
        do_reset();
        run_cycles(7, 100, 100, 1'b1, 0);
        check("t6_in_send", {63'd0, out_valid}, 64'd1);
        do_reset();
        dataI = {32'd100, 32'd100};
        dataQ = {32'd100, 32'd100};
        seen  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (out_valid && !seen) begin
                check("t6_gap_word", {32'd0, dataout}, 64'd400);
                seen = 1'b1;
            end
            in_valid = (c % 3 == 0);
        end
        check("t6_gap_seen", {63'd0, seen}, 64'd1);
        check("t6_no_drop", {63'd0, overrun}, 64'd0);
        run_cycles(20, 0, 100, 1'b0, 0);

        // Randomized segments at several shifts, including the largest legal one
        do_reset();
        shift = 6'd2;
        for (int i = 0; i < 150; i++) begin
            dec_fact = 16'($urandom_range(0, 6));
            run_cycles(10, 80, 75, 1'b1, 6);
        end
        do_reset();
        shift = 6'd20;
        for (int i = 0; i < 100; i++) begin
            dec_fact = 16'($urandom_range(1, 12));
            run_cycles(10, 90, 90, 1'b1, 4);
        end
        do_reset();
        shift = 6'd47;
        for (int i = 0; i < 30; i++) begin
            dec_fact = 16'($urandom_range(3, 9));
            run_cycles(10, 100, 100, 1'b1, 0);
        end
        run_cycles(20, 0, 100, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
